// File: rtl/gcn_pkg.sv
// Shared GCN datapath constants and the adjacency-aggregation state type.
// Used by adj_row_aggregator and its downstream consumer max_finder.
package gcn_pkg;

    localparam int GCN_NUM_NODES          = 6;
    localparam int GCN_DOT_PROD_COLS      = 3;
    localparam int GCN_FMWM_WIDTH         = 16;
    localparam int GCN_ADJ_DOT_PROD_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADJ_RD = 3'd1,
        FETCH  = 3'd2,
        DRAIN  = 3'd3,
        EMIT   = 3'd4,
        DONE   = 3'd5
    } agg_state_t;

endpackage

// File: rtl/row_accumulator.sv
// Parallel per-column wrapping adders; sum_next exposes the post-add value
// so the owner can capture a final row in the same cycle as the last add.
module row_accumulator #(
    parameter int COLS  = 3,
    parameter int IN_W  = 16,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             add_en,
    input  logic [IN_W-1:0]  addend   [0:COLS-1],
    output logic [ACC_W-1:0] sum_next [0:COLS-1]
);

    logic [ACC_W-1:0] sum [0:COLS-1];

    // Unsigned zero-extension; overflow wraps modulo 2^ACC_W.
    always_comb begin
        for (int i = 0; i < COLS; i++) begin
            sum_next[i] = sum[i] + (add_en ? ACC_W'(addend[i]) : '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '{default: '0};
        end else if (clear) begin
            sum <= '{default: '0};
        end else begin
            sum <= sum_next;
        end
    end

endmodule

// File: rtl/adj_row_aggregator.sv
// Sums the FM x WM rows of every neighbour named in one adjacency row, one
// node at a time, and presents each aggregated row for a single cycle.
module adj_row_aggregator
    import gcn_pkg::*;
#(
    parameter int NUM_NODES          = GCN_NUM_NODES,
    parameter int DOT_PROD_COLS      = GCN_DOT_PROD_COLS,
    parameter int FMWM_WIDTH         = GCN_FMWM_WIDTH,
    parameter int ADJ_DOT_PROD_WIDTH = GCN_ADJ_DOT_PROD_WIDTH,
    parameter int NODE_ADDR_WIDTH    = $clog2(NUM_NODES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          adj_read_en,
    output logic [NODE_ADDR_WIDTH-1:0]    adj_read_address,
    input  logic [NUM_NODES-1:0]          adj_read_data,
    output logic                          fm_wm_read_en,
    output logic [NODE_ADDR_WIDTH-1:0]    fm_wm_read_address,
    input  logic [FMWM_WIDTH-1:0]         fm_wm_read_data   [0:DOT_PROD_COLS-1],
    output logic                          is_read_row,
    output logic [NODE_ADDR_WIDTH-1:0]    row_index,
    output logic [ADJ_DOT_PROD_WIDTH-1:0] ADJ_FM_WM_Row     [0:DOT_PROD_COLS-1],
    output logic [ADJ_DOT_PROD_WIDTH-1:0] r_ADJ_FM_WM_Row   [0:DOT_PROD_COLS-1],
    output logic                          busy,
    output logic                          done
);

    localparam logic [NODE_ADDR_WIDTH-1:0] LAST_NODE = NODE_ADDR_WIDTH'(NUM_NODES - 1);

    agg_state_t                    state;
    logic [NODE_ADDR_WIDTH-1:0]    row;
    logic [NODE_ADDR_WIDTH-1:0]    col;
    logic [NODE_ADDR_WIDTH-1:0]    prev_col;
    logic [NUM_NODES-1:0]          adj_row_q;
    logic                          start_armed;
    logic                          acc_clear;
    logic                          acc_add;
    logic [ADJ_DOT_PROD_WIDTH-1:0] acc_next [0:DOT_PROD_COLS-1];

    assign prev_col = col - NODE_ADDR_WIDTH'(1);

    // Memory returns lag the address by one cycle, so each FETCH cycle adds
    // the column requested in the previous one; DRAIN adds the final column.
    always_comb begin
        acc_clear = (state == ADJ_RD);
        acc_add   = 1'b0;
        if (state == FETCH && col != '0) begin
            acc_add = adj_row_q[prev_col];
        end else if (state == DRAIN) begin
            acc_add = adj_row_q[NUM_NODES-1];
        end
    end

    row_accumulator #(
        .COLS  (DOT_PROD_COLS),
        .IN_W  (FMWM_WIDTH),
        .ACC_W (ADJ_DOT_PROD_WIDTH)
    ) u_row_accumulator (
        .clk      (clk),
        .reset    (reset),
        .clear    (acc_clear),
        .add_en   (acc_add),
        .addend   (fm_wm_read_data),
        .sum_next (acc_next)
    );

    assign adj_read_en        = (state == ADJ_RD);
    assign adj_read_address   = row;
    assign fm_wm_read_en      = (state == FETCH);
    assign fm_wm_read_address = col;
    assign is_read_row        = (state == EMIT);
    assign done               = (state == DONE);
    assign busy               = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            row             <= '0;
            col             <= '0;
            adj_row_q       <= '0;
            start_armed     <= 1'b0;
            row_index       <= '0;
            ADJ_FM_WM_Row   <= '{default: '0};
            r_ADJ_FM_WM_Row <= '{default: '0};
        end else begin
            // A start coinciding with the first edge after reset release is dropped.
            start_armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (start && start_armed) begin
                        row   <= '0;
                        state <= ADJ_RD;
                    end
                end
                ADJ_RD: begin
                    col   <= '0;
                    state <= FETCH;
                end
                FETCH: begin
                    if (col == '0) begin
                        adj_row_q <= adj_read_data;
                    end
                    if (col == LAST_NODE) begin
                        state <= DRAIN;
                    end else begin
                        col <= col + NODE_ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    ADJ_FM_WM_Row <= acc_next;
                    row_index     <= row;
                    state         <= EMIT;
                end
                EMIT: begin
                    r_ADJ_FM_WM_Row <= ADJ_FM_WM_Row;
                    if (row == LAST_NODE) begin
                        state <= DONE;
                    end else begin
                        row   <= row + NODE_ADDR_WIDTH'(1);
                        state <= ADJ_RD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adj_row_aggregator.sv
// Directed-plus-random bench for adj_row_aggregator: expected rows come from
// a plain adjacency-times-feature matrix product over the bench memories.
module tb_adj_row_aggregator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        adj_read_en;
    logic [2:0]  adj_read_address;
    logic [5:0]  adj_read_data;
    logic        fm_wm_read_en;
    logic [2:0]  fm_wm_read_address;
    logic [15:0] fm_wm_read_data [0:2];
    logic        is_read_row;
    logic [2:0]  row_index;
    logic [15:0] agg_row   [0:2];
    logic [15:0] agg_row_q [0:2];
    logic        busy;
    logic        done;

    logic [5:0]  adj_mem  [0:5];
    logic [15:0] fm_mem   [0:5][0:2];
    logic [15:0] exp_rows [0:5][0:2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adj_row_aggregator dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .adj_read_en        (adj_read_en),
        .adj_read_address   (adj_read_address),
        .adj_read_data      (adj_read_data),
        .fm_wm_read_en      (fm_wm_read_en),
        .fm_wm_read_address (fm_wm_read_address),
        .fm_wm_read_data    (fm_wm_read_data),
        .is_read_row        (is_read_row),
        .row_index          (row_index),
        .ADJ_FM_WM_Row      (agg_row),
        .r_ADJ_FM_WM_Row    (agg_row_q),
        .busy               (busy),
        .done               (done)
    );

    // Synchronous-read memories with one cycle of latency.
    always @(posedge clk) begin
        if (adj_read_en) adj_read_data <= adj_mem[adj_read_address];
        if (fm_wm_read_en) begin
            for (int c = 0; c < 3; c++) fm_wm_read_data[c] <= fm_mem[fm_wm_read_address][c];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Row i = sum over neighbours k of fm row k, modulo 2^16.
    task automatic compute_expected();
        logic [15:0] s;
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 3; c++) begin
                s = 16'd0;
                for (int k = 0; k < 6; k++) begin
                    if (adj_mem[i][k]) s = s + fm_mem[k][c];
                end
                exp_rows[i][c] = s;
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_is_read_row"}, 32'(is_read_row), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_row_index"}, 32'(row_index), 32'd0);
        check({name, "_fm_wm_read_en"}, 32'(fm_wm_read_en), 32'd0);
        check({name, "_adj_read_en"}, 32'(adj_read_en), 32'd0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("%s_row_c%0d", name, c), 32'(agg_row[c]), 32'd0);
            check($sformatf("%s_rrow_c%0d", name, c), 32'(agg_row_q[c]), 32'd0);
        end
    endtask

    // n counts rising edges since start was raised (the start edge is n=1).
    task automatic run_pass(input string name, input bit repulse, input int abort_at);
        int r;
        compute_expected();
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            start = repulse && (n == 4 || n == 29 || n == 54);
            if (n == abort_at) begin
                reset = 1'b0;
                #1;
                check_all_zero({name, "_abort"});
                break;
            end
            check($sformatf("%s_rd_n%0d", name, n), 32'(is_read_row),
                  32'((n % 9 == 0) && n >= 9 && n <= 54));
            check($sformatf("%s_done_n%0d", name, n), 32'(done), 32'(n == 55));
            check($sformatf("%s_busy_n%0d", name, n), 32'(busy), 32'(n <= 55));
            if ((n % 9 == 0) && n >= 9 && n <= 54) begin
                r = n / 9 - 1;
                check($sformatf("%s_idx_r%0d", name, r), 32'(row_index), 32'(r));
                for (int c = 0; c < 3; c++)
                    check($sformatf("%s_row_r%0d_c%0d", name, r, c), 32'(agg_row[c]),
                          32'(exp_rows[r][c]));
            end
            if (((n - 1) % 9 == 0) && n >= 10 && n <= 55) begin
                r = (n - 1) / 9 - 1;
                for (int c = 0; c < 3; c++)
                    check($sformatf("%s_rrow_r%0d_c%0d", name, r, c), 32'(agg_row_q[c]),
                          32'(exp_rows[r][c]));
            end
        end
        start = 1'b0;
    endtask

    task automatic randomize_mems();
        for (int i = 0; i < 6; i++) begin
            adj_mem[i] = 6'($urandom);
            for (int c = 0; c < 3; c++) fm_mem[i][c] = 16'($urandom);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_busy", 32'(busy), 32'd0);

        for (int k = 0; k < 6; k++) begin
            adj_mem[k]   = 6'(1 << k);
            fm_mem[k][0] = 16'(k + 1);
            fm_mem[k][1] = 16'(2 * k);
            fm_mem[k][2] = 16'(10 - k);
        end
        run_pass("identity", 1'b0, 0);

        for (int k = 0; k < 6; k++) adj_mem[k] = 6'h3F;
        run_pass("all_ones", 1'b0, 0);

        randomize_mems();
        adj_mem[2] = 6'h00;
        run_pass("zero_row2", 1'b0, 0);

        for (int k = 0; k < 6; k++) begin
            adj_mem[k] = 6'h3F;
            for (int c = 0; c < 3; c++) fm_mem[k][c] = 16'hFFFF;
        end
        run_pass("wrap", 1'b0, 0);

        randomize_mems();
        run_pass("repulse", 1'b1, 0);
        randomize_mems();
        run_pass("fresh", 1'b0, 0);

        randomize_mems();
        run_pass("abort", 1'b0, 31);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_at_release_busy", 32'(busy), 32'd0);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check($sformatf("idle_rd_%0d", n), 32'(is_read_row), 32'd0);
            check($sformatf("idle_busy_%0d", n), 32'(busy), 32'd0);
        end
        randomize_mems();
        run_pass("recover", 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
